multi_signal_hold: RTL and testbench

//  Multi-channel synchroniser and hold/stretch stage for slow control and status bits crossing into a fabric clock domain.

---
 rtl/multi_signal_hold_if.sv | 34 +++
 rtl/multi_signal_hold.sv | 160 ++++++++++++++++
 tb/tb_multi_signal_hold.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_signal_hold_if.sv
// Bundle of the multi_signal_hold data, control and status signals.
// Optional event-counter signals appear when MULTI_HOLD_EVENT_CNT_EN is defined.
interface multi_signal_hold_if #(
  parameter int NUM_CH     = 4,
  parameter int HOLD_WIDTH = 8
);
  logic [NUM_CH-1:0]     data_in;
  logic [HOLD_WIDTH-1:0] hold_cycles;
  logic [NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]     data_out;
  logic [NUM_CH-1:0]     active;
`ifdef MULTI_HOLD_EVENT_CNT_EN
  logic                  cnt_clr;
  logic [NUM_CH*16-1:0]  event_cnt;

  modport master (
    output data_in, hold_cycles, mode, cnt_clr,
    input  data_out, active, event_cnt
  );
  modport slave (
    input  data_in, hold_cycles, mode, cnt_clr,
    output data_out, active, event_cnt
  );
`else
  modport master (
    output data_in, hold_cycles, mode,
    input  data_out, active
  );
  modport slave (
    input  data_in, hold_cycles, mode,
    output data_out, active
  );
`endif
endinterface

// File: rtl/multi_signal_hold.sv
// multi_signal_hold: per-channel synchroniser followed by a change-lockout
// (mode 0) or retriggerable pulse-stretch (mode 1) hold stage.
// Hold length H comes from hold_cycles; the counter is loaded with H-1
// (or 0 for H<=1) so an output level lasts at least H cycles.
// Optional feature macro: MULTI_HOLD_EVENT_CNT_EN adds saturating 16-bit
// per-channel transition counters (event_cnt) with a synchronous clear (cnt_clr).
module multi_signal_hold #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  multi_signal_hold_if.slave  bus
);

  localparam logic [HOLD_WIDTH-1:0] CNT_ZERO = {HOLD_WIDTH{1'b0}};
  localparam logic [HOLD_WIDTH-1:0] CNT_ONE  = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0]     sync_r [SYNC_STAGES];
  logic [NUM_CH-1:0]     sync_s;
  logic [HOLD_WIDTH-1:0] load_s;
  logic [HOLD_WIDTH-1:0] cnt_r     [NUM_CH];
  logic [HOLD_WIDTH-1:0] cnt_nxt_s [NUM_CH];
  logic [NUM_CH-1:0]     out_r;
  logic [NUM_CH-1:0]     out_nxt_s;
  logic [NUM_CH-1:0]     active_r;
  logic [NUM_CH-1:0]     active_nxt_s;

  // Synchroniser chain: every channel passes through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {NUM_CH{1'b0}};
      end
    end else begin
      sync_r[0] <= bus.data_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Counter load value: H-1 for H>1, otherwise 0 so the channel never holds.
  always_comb begin
    if (bus.hold_cycles > CNT_ONE) begin
      load_s = bus.hold_cycles - CNT_ONE;
    end else begin
      load_s = CNT_ZERO;
    end
  end

  // Per-channel next output/counter from {mode, holding}; a running hold
  // only counts down, so hold_cycles changes never disturb it.
  always_comb begin
    out_nxt_s    = out_r;
    active_nxt_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      case ({bus.mode[i], (cnt_r[i] != CNT_ZERO)})
        2'b00: begin
          if (sync_s[i] != out_r[i]) begin
            out_nxt_s[i] = sync_s[i];
            cnt_nxt_s[i] = load_s;
          end else begin
            out_nxt_s[i] = out_r[i];
            cnt_nxt_s[i] = cnt_r[i];
          end
        end
        2'b01: begin
          out_nxt_s[i] = out_r[i];
          cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
        end
        2'b10: begin
          if (sync_s[i]) begin
            out_nxt_s[i] = 1'b1;
            cnt_nxt_s[i] = load_s;
          end else begin
            out_nxt_s[i] = 1'b0;
            cnt_nxt_s[i] = cnt_r[i];
          end
        end
        2'b11: begin
          // Holding output keeps its level; a new pulse retriggers the count.
          if (sync_s[i]) begin
            out_nxt_s[i] = 1'b1;
            cnt_nxt_s[i] = load_s;
          end else begin
            out_nxt_s[i] = out_r[i];
            cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
          end
        end
        default: begin
          out_nxt_s[i] = out_r[i];
          cnt_nxt_s[i] = cnt_r[i];
        end
      endcase
      active_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
    end
  end

  // Output, counter and active flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r    <= {NUM_CH{1'b0}};
      active_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      out_r    <= out_nxt_s;
      active_r <= active_nxt_s;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign bus.data_out = out_r;
  assign bus.active   = active_r;

`ifdef MULTI_HOLD_EVENT_CNT_EN
  logic [15:0]          ev_r [NUM_CH];
  logic [NUM_CH*16-1:0] ev_pack_s;

  // Saturating transition counters; a clear beats a coincident transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ev_r[i] <= 16'h0000;
      end
    end else if (bus.cnt_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ev_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((out_nxt_s[i] != out_r[i]) && (ev_r[i] != 16'hFFFF)) begin
          ev_r[i] <= ev_r[i] + 16'h0001;
        end else begin
          ev_r[i] <= ev_r[i];
        end
      end
    end
  end

  // Pack the per-channel counters, channel i at bits [16i+15:16i].
  always_comb begin
    ev_pack_s = {(NUM_CH*16){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ev_pack_s[16*i +: 16] = ev_r[i];
    end
  end

  assign bus.event_cnt = ev_pack_s;
`endif

endmodule

// File: tb/tb_multi_signal_hold.sv
// Scoreboard bench for multi_signal_hold (NUM_CH=4, HOLD_WIDTH=8, SYNC_STAGES=2).
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_multi_signal_hold;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_signal_hold_if #(.NUM_CH(4), .HOLD_WIDTH(8)) bus ();

  multi_signal_hold #(.NUM_CH(4), .HOLD_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] om;
    logic [3:0] oe;
    logic [3:0] am;
    logic [3:0] ae;
    int         tid;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int b;

  task automatic push(input int c, input logic [3:0] om, input logic [3:0] oe,
                      input logic [3:0] am, input logic [3:0] ae, input int tid);
    exp_t x;
    x.c = c; x.om = om; x.oe = oe; x.am = am; x.ae = ae; x.tid = tid;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c < cyc) begin
        errors++;
        $display("FAIL t%0d: expectation for cycle %0d not checked until cycle %0d", e.tid, e.c, cyc);
      end else if ((((bus.data_out ^ e.oe) & e.om) != 4'b0) ||
                   (((bus.active ^ e.ae) & e.am) != 4'b0)) begin
        errors++;
        $display("FAIL t%0d cycle %0d: data_out=%b active=%b, required data_out=%b (mask %b) active=%b (mask %b)",
                 e.tid, e.c - b, bus.data_out, bus.active, e.oe, e.om, e.ae, e.am);
      end
    end
  end

  logic [1:0] pat0 [11];
  logic [1:0] pat1 [11];

  initial begin
    bus.data_in     = 4'b0;
    bus.mode        = 4'b0;
    bus.hold_cycles = 8'd0;
`ifdef MULTI_HOLD_EVENT_CNT_EN
    bus.cnt_clr     = 1'b0;
`endif
    pat0 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    pat1 = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00};

    // Reset state
    cycles(3);
    chk("reset data_out", {12'b0, bus.data_out}, 16'h0000);
    chk("reset active", {12'b0, bus.active}, 16'h0000);
    rst = 1'b0;
    b = cyc;
    push(b + 1, 4'hF, 4'h0, 4'hF, 4'h0, 0);
    cycles(4);

    // T1: mode 0, H=4, one-cycle input on ch0
    bus.mode = 4'b0000; bus.hold_cycles = 8'd4;
    @(negedge clk); b = cyc; bus.data_in = 4'b0001;
    push(b + 3, 4'hF, 4'b0001, 4'hF, 4'b0001, 1);
    push(b + 4, 4'hF, 4'b0001, 4'hF, 4'b0001, 1);
    push(b + 5, 4'hF, 4'b0001, 4'hF, 4'b0001, 1);
    push(b + 6, 4'hF, 4'b0001, 4'hF, 4'b0000, 1);
    push(b + 7, 4'hF, 4'b0000, 4'hF, 4'b0001, 1);
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(14);

    // T2a: mode 1, H=5, single pulse -> 5 high cycles
    bus.mode = 4'b0001; bus.hold_cycles = 8'd5;
    @(negedge clk); b = cyc; bus.data_in = 4'b0001;
    for (int k = 3; k <= 6; k++) push(b + k, 4'hF, 4'b0001, 4'hF, 4'b0001, 2);
    push(b + 7, 4'hF, 4'b0001, 4'hF, 4'b0000, 2);
    push(b + 8, 4'hF, 4'b0000, 4'hF, 4'b0000, 2);
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(12);

    // T2b: two pulses 3 cycles apart -> one 8-cycle pulse
    @(negedge clk); b = cyc; bus.data_in = 4'b0001;
    for (int k = 3; k <= 10; k++) push(b + k, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 3);
    push(b + 11, 4'hF, 4'b0000, 4'hF, 4'b0000, 3);
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(2);      bus.data_in = 4'b0001;
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(12);

    // T3: H=0 then H=1, pass-through on ch0 (mode 0) and ch1 (mode 1)
    bus.mode = 4'b0010; bus.hold_cycles = 8'd0;
    @(negedge clk); b = cyc;
    for (int k = 0; k < 11; k++) push(b + k + 3, 4'hF, {2'b00, pat0[k]}, 4'hF, 4'h0, 4);
    for (int k = 0; k < 11; k++) begin
      bus.data_in = {2'b00, pat0[k]};
      @(negedge clk);
    end
    cycles(4);
    bus.hold_cycles = 8'd1;
    @(negedge clk); b = cyc;
    for (int k = 0; k < 11; k++) push(b + k + 3, 4'hF, {2'b00, pat1[k]}, 4'hF, 4'h0, 5);
    for (int k = 0; k < 11; k++) begin
      bus.data_in = {2'b00, pat1[k]};
      @(negedge clk);
    end
    cycles(4);

    // T4: ch1 mode 1 with H=200; H drops to 2 mid-count; ch0 works independently
    bus.mode = 4'b0010; bus.hold_cycles = 8'd200;
    @(negedge clk); b = cyc; bus.data_in = 4'b0010;
    push(b + 3,   4'hF,    4'b0010, 4'hF,    4'b0010, 6);
    push(b + 23,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 6);
    push(b + 24,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 6);
    push(b + 25,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 6);
    push(b + 100, 4'hF,    4'b0010, 4'hF,    4'b0010, 6);
    push(b + 201, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 6);
    push(b + 202, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 6);
    push(b + 203, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 6);
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(9);      bus.hold_cycles = 8'd2;
    cycles(10);     bus.data_in = 4'b0001;
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(190);

    // T5: asynchronous reset in the middle of a hold
    bus.mode = 4'b0001; bus.hold_cycles = 8'd10;
    @(negedge clk); b = cyc; bus.data_in = 4'b0001;
    push(b + 3, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 7);
    push(b + 5, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 7);
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(5);
    #2 rst = 1'b1;
    #1;
    chk("async reset data_out", {12'b0, bus.data_out}, 16'h0000);
    chk("async reset active", {12'b0, bus.active}, 16'h0000);
    cycles(2);
    rst = 1'b0;
    bus.hold_cycles = 8'd3;
    @(negedge clk); b = cyc; bus.data_in = 4'b0001;
    for (int k = 3; k <= 5; k++) push(b + k, 4'hF, 4'b0001, 4'b0000, 4'b0000, 8);
    push(b + 6, 4'hF, 4'b0000, 4'hF, 4'b0000, 8);
    @(negedge clk); bus.data_in = 4'b0000;
    cycles(10);

`ifdef MULTI_HOLD_EVENT_CNT_EN
    // T6: event counters, saturation and clear-wins
    bus.mode = 4'b0000; bus.hold_cycles = 8'd0;
    bus.cnt_clr = 1'b1;
    @(negedge clk); bus.cnt_clr = 1'b0;
    @(negedge clk);
    chk("evcnt cleared", bus.event_cnt[15:0], 16'h0000);
    for (int k = 0; k < 5; k++) begin
      bus.data_in = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
    end
    bus.data_in = 4'b0000;
    cycles(8);
    chk("evcnt ch2 six", bus.event_cnt[47:32], 16'd6);
    chk("evcnt ch0 zero", bus.event_cnt[15:0], 16'd0);
    for (int k = 0; k < 65540; k++) begin
      bus.data_in = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      @(negedge clk);
    end
    bus.data_in = 4'b0000;
    cycles(6);
    chk("evcnt ch3 saturated", bus.event_cnt[63:48], 16'hFFFF);
    chk("evcnt ch2 unaffected", bus.event_cnt[47:32], 16'd6);
    @(negedge clk); b = cyc; bus.data_in = 4'b0100;
    @(negedge clk); bus.data_in = 4'b0000;
    @(negedge clk); bus.cnt_clr = 1'b1;
    @(negedge clk); bus.cnt_clr = 1'b0;
    chk("evcnt clear wins ch2", bus.event_cnt[47:32], 16'd0);
    chk("evcnt clear ch3", bus.event_cnt[63:48], 16'd0);
    @(negedge clk);
    chk("evcnt after clear", bus.event_cnt[47:32], 16'd1);
    cycles(4);
`endif

    // Drain: every expectation must have been consumed.
    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
